// File: rtl/alu_operand_stage_if.sv
// Decode-to-ALU operand stage bundle: decode handshake, bypass sources, ALU-side outputs.
// Master is the surrounding pipeline (decode/EX/MEM/WB); slave is the operand stage.
interface alu_operand_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  id_valid;
    logic                  id_ready;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic [DATA_WIDTH-1:0] id_rs1_data;
    logic [DATA_WIDTH-1:0] id_rs2_data;
    logic [DATA_WIDTH-1:0] id_imm;
    logic                  id_alusrc;
    logic [2:0]            id_aluctrl;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  flush;
    logic [REG_ADDR_W-1:0] exmem_rd;
    logic                  exmem_regwrite;
    logic [DATA_WIDTH-1:0] exmem_result;
    logic [REG_ADDR_W-1:0] memwb_rd;
    logic                  memwb_regwrite;
    logic [DATA_WIDTH-1:0] memwb_result;
    logic                  ex_valid;
    logic                  ex_ready;
    logic [DATA_WIDTH-1:0] ALUop1;
    logic [DATA_WIDTH-1:0] ALUop2;
    logic [2:0]            ALUctrl;
    logic [DATA_WIDTH-1:0] ex_store_data;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_regwrite;
    logic                  ex_memread;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm,
               id_alusrc, id_aluctrl, id_rd_addr, id_regwrite, id_memread, flush,
               exmem_rd, exmem_regwrite, exmem_result, memwb_rd, memwb_regwrite,
               memwb_result, ex_ready,
        input  id_ready, ex_valid, ALUop1, ALUop2, ALUctrl, ex_store_data,
               ex_rd_addr, ex_regwrite, ex_memread
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm,
               id_alusrc, id_aluctrl, id_rd_addr, id_regwrite, id_memread, flush,
               exmem_rd, exmem_regwrite, exmem_result, memwb_rd, memwb_regwrite,
               memwb_result, ex_ready,
        output id_ready, ex_valid, ALUop1, ALUop2, ALUctrl, ex_store_data,
               ex_rd_addr, ex_regwrite, ex_memread
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX register feeding the ALU, with EX/MEM and MEM/WB operand bypass on the output side.
// Latency: 1 cycle from id acceptance to ALU inputs; 1 instruction/cycle without hazards.
// Backpressure: id_ready drops on ex stall, load-use (one bubble) or flush.
module alu_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_operand_stage_if.slave   bus
);
    logic                  vld;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [DATA_WIDTH-1:0] rs1_dat;
    logic [DATA_WIDTH-1:0] rs2_dat;
    logic [DATA_WIDTH-1:0] imm;
    logic                  alusrc;
    logic [2:0]            aluctrl;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  regwrite;
    logic                  memread;

    logic ex_hit1, ex_hit2, wb_hit1, wb_hit2;
    logic [DATA_WIDTH-1:0] fwd1, fwd2;
    logic load_use, accept;

    // x0 is hardwired zero, so a pending write to it must never be bypassed.
    assign ex_hit1 = bus.exmem_regwrite && (bus.exmem_rd != '0) && (bus.exmem_rd == rs1_addr);
    assign ex_hit2 = bus.exmem_regwrite && (bus.exmem_rd != '0) && (bus.exmem_rd == rs2_addr);
    assign wb_hit1 = bus.memwb_regwrite && (bus.memwb_rd != '0) && (bus.memwb_rd == rs1_addr);
    assign wb_hit2 = bus.memwb_regwrite && (bus.memwb_rd != '0) && (bus.memwb_rd == rs2_addr);

    assign fwd1 = ex_hit1 ? bus.exmem_result : (wb_hit1 ? bus.memwb_result : rs1_dat);
    assign fwd2 = ex_hit2 ? bus.exmem_result : (wb_hit2 ? bus.memwb_result : rs2_dat);

    // rs2 is compared even for immediate forms; stores still need it as data.
    assign load_use = vld && memread && (rd_addr != '0) && bus.id_valid &&
                      ((bus.id_rs1_addr == rd_addr) || (bus.id_rs2_addr == rd_addr));

    assign bus.id_ready = (!vld || bus.ex_ready) && !load_use && !bus.flush;
    assign accept       = bus.id_valid && bus.id_ready;

    assign bus.ex_valid      = vld;
    assign bus.ALUop1        = fwd1;
    assign bus.ALUop2        = alusrc ? imm : fwd2;
    assign bus.ALUctrl       = aluctrl;
    assign bus.ex_store_data = fwd2;
    assign bus.ex_rd_addr    = rd_addr;
    assign bus.ex_regwrite   = regwrite && vld;
    assign bus.ex_memread    = memread && vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld      <= 1'b0;
            rs1_addr <= '0;
            rs2_addr <= '0;
            rs1_dat  <= '0;
            rs2_dat  <= '0;
            imm      <= '0;
            alusrc   <= 1'b0;
            aluctrl  <= 3'b000;
            rd_addr  <= '0;
            regwrite <= 1'b0;
            memread  <= 1'b0;
        end else if (bus.flush) begin
            vld <= 1'b0;
        end else if (accept) begin
            vld      <= 1'b1;
            rs1_addr <= bus.id_rs1_addr;
            rs2_addr <= bus.id_rs2_addr;
            rs1_dat  <= bus.id_rs1_data;
            rs2_dat  <= bus.id_rs2_data;
            imm      <= bus.id_imm;
            alusrc   <= bus.id_alusrc;
            aluctrl  <= bus.id_aluctrl;
            rd_addr  <= bus.id_rd_addr;
            regwrite <= bus.id_regwrite;
            memread  <= bus.id_memread;
        end else if (!vld || bus.ex_ready) begin
            vld <= 1'b0;
        end else begin
            // Stalled: capture bypassed values so a producer leaving MEM/WB is not lost.
            rs1_dat <= fwd1;
            rs2_dat <= fwd2;
        end
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: expected ALU inputs queued at drive time,
// popped and compared whenever the stage hands an instruction to execute.
module tb_alu_operand_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_operand_stage_if #(.DATA_WIDTH(32), .REG_ADDR_W(5)) bus ();

    alu_operand_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] sd;
        logic [2:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                            input logic alusrc, input logic [2:0] ctrl, input logic [4:0] rd,
                            input logic rw, input logic mr);
        bus.id_valid    = 1'b1;
        bus.id_rs1_addr = rs1;
        bus.id_rs2_addr = rs2;
        bus.id_rs1_data = d1;
        bus.id_rs2_data = d2;
        bus.id_imm      = imm;
        bus.id_alusrc   = alusrc;
        bus.id_aluctrl  = ctrl;
        bus.id_rd_addr  = rd;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
    endtask

    task automatic push_exp(input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] sd,
                            input logic [2:0] ctrl, input logic [4:0] rd, input logic rw,
                            input logic mr);
        exp_t e;
        e.op1 = op1; e.op2 = op2; e.sd = sd; e.ctrl = ctrl; e.rd = rd; e.rw = rw; e.mr = mr;
        sbq.push_back(e);
    endtask

    // An instruction visible with ex_ready high at the negedge is consumed at the next edge.
    always @(negedge clk) begin
        if (rst_n && bus.ex_valid && bus.ex_ready) begin
            if (sbq.size() == 0) begin
                check("sb_empty", 32'(sbq.size()), 32'd1);
            end else begin
                mon_e = sbq.pop_front();
                check("op1",     bus.ALUop1,               mon_e.op1);
                check("op2",     bus.ALUop2,               mon_e.op2);
                check("store",   bus.ex_store_data,        mon_e.sd);
                check("ctrl",    32'(bus.ALUctrl),         32'(mon_e.ctrl));
                check("rd",      32'(bus.ex_rd_addr),      32'(mon_e.rd));
                check("regwr",   32'(bus.ex_regwrite),     32'(mon_e.rw));
                check("memrd",   32'(bus.ex_memread),      32'(mon_e.mr));
            end
        end
    end

    logic [4:0]  s_rs1  [4] = '{5'd1, 5'd6, 5'd10, 5'd12};
    logic [4:0]  s_rs2  [4] = '{5'd2, 5'd8, 5'd11, 5'd13};
    logic [31:0] s_d1   [4] = '{32'h10, 32'hA, 32'hF0F0, 32'h1234_5678};
    logic [31:0] s_d2   [4] = '{32'h42, 32'hB, 32'h0FF0, 32'h8765_4321};
    logic [31:0] s_imm  [4] = '{32'hFFFF_FFFC, 32'h7, 32'h9, 32'h3};
    logic        s_src  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  s_ctrl [4] = '{3'b000, 3'b001, 3'b010, 3'b101};
    logic [4:0]  s_rd   [4] = '{5'd4, 5'd9, 5'd0, 5'd15};
    logic        s_rw   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0;
        drive_id(5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0);
        bus.flush          = 1'b0;
        bus.exmem_rd       = 5'd0;
        bus.exmem_regwrite = 1'b0;
        bus.exmem_result   = 32'h0;
        bus.memwb_rd       = 5'd0;
        bus.memwb_regwrite = 1'b0;
        bus.memwb_result   = 32'h0;
        bus.ex_ready       = 1'b1;

        // Reset with decode offering an instruction.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld",   32'(bus.ex_valid),    32'd0);
        check("rst_ctrl",  32'(bus.ALUctrl),     32'd0);
        check("rst_op1",   bus.ALUop1,           32'd0);
        check("rst_op2",   bus.ALUop2,           32'd0);
        check("rst_regwr", 32'(bus.ex_regwrite), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.id_valid = 1'b0;
        @(negedge clk);
        check("rst_rdy", 32'(bus.id_ready), 32'd1);
        tick();

        // Back-to-back stream, includes imm/store-data case as the first entry.
        for (int i = 0; i < 4; i++) begin
            drive_id(s_rs1[i], s_rs2[i], s_d1[i], s_d2[i], s_imm[i], s_src[i], s_ctrl[i],
                     s_rd[i], s_rw[i], 1'b0);
            push_exp(s_d1[i], s_src[i] ? s_imm[i] : s_d2[i], s_d2[i], s_ctrl[i], s_rd[i],
                     s_rw[i], 1'b0);
            @(negedge clk);
            check("thru_rdy", 32'(bus.id_ready), 32'd1);
            tick();
        end
        bus.id_valid = 1'b0;
        tick();

        // EX/MEM beats MEM/WB; MEM/WB used once EX/MEM stops writing.
        bus.exmem_rd = 5'd5; bus.exmem_regwrite = 1'b1; bus.exmem_result = 32'h99;
        bus.memwb_rd = 5'd5; bus.memwb_regwrite = 1'b1; bus.memwb_result = 32'h77;
        bus.ex_ready = 1'b0;
        drive_id(5'd5, 5'd2, 32'h11, 32'h22, 32'h0, 1'b0, 3'b000, 5'd12, 1'b1, 1'b0);
        tick();
        bus.id_valid = 1'b0;
        @(negedge clk);
        check("fwd_exmem", bus.ALUop1, 32'h99);
        check("fwd_vld",   32'(bus.ex_valid), 32'd1);
        tick();
        bus.exmem_regwrite = 1'b0;
        @(negedge clk);
        check("fwd_memwb", bus.ALUop1, 32'h77);
        tick();
        bus.memwb_regwrite = 1'b0;
        push_exp(32'h77, 32'h22, 32'h22, 3'b000, 5'd12, 1'b1, 1'b0);
        bus.ex_ready = 1'b1;
        tick();

        // x0 is never bypassed; rs2 bypass reaches store data even with an immediate.
        bus.exmem_rd = 5'd0; bus.exmem_regwrite = 1'b1; bus.exmem_result = 32'h99;
        bus.memwb_rd = 5'd5; bus.memwb_regwrite = 1'b1; bus.memwb_result = 32'h77;
        drive_id(5'd0, 5'd5, 32'h0, 32'h55, 32'h8, 1'b1, 3'b011, 5'd1, 1'b1, 1'b0);
        push_exp(32'h0, 32'h8, 32'h77, 3'b011, 5'd1, 1'b1, 1'b0);
        tick();
        bus.id_valid = 1'b0;
        tick();
        bus.exmem_regwrite = 1'b0;
        bus.memwb_regwrite = 1'b0;

        // Stall refresh: MEM/WB producer retires while the consumer is held.
        bus.ex_ready = 1'b0;
        drive_id(5'd7, 5'd0, 32'h5, 32'h0, 32'h0, 1'b0, 3'b001, 5'd8, 1'b1, 1'b0);
        tick();
        bus.id_valid = 1'b0;
        bus.memwb_rd = 5'd7; bus.memwb_regwrite = 1'b1; bus.memwb_result = 32'h1234;
        @(negedge clk);
        check("stall_fwd", bus.ALUop1, 32'h1234);
        tick();
        tick();
        bus.memwb_regwrite = 1'b0;
        @(negedge clk);
        check("stall_keep", bus.ALUop1, 32'h1234);
        tick();
        push_exp(32'h1234, 32'h0, 32'h0, 3'b001, 5'd8, 1'b1, 1'b0);
        bus.ex_ready = 1'b1;
        tick();

        // Load-use through rs2 of an immediate-form instruction: exactly one bubble.
        drive_id(5'd1, 5'd0, 32'h100, 32'h0, 32'h4, 1'b1, 3'b000, 5'd3, 1'b1, 1'b1);
        push_exp(32'h100, 32'h4, 32'h0, 3'b000, 5'd3, 1'b1, 1'b1);
        tick();
        drive_id(5'd2, 5'd3, 32'h20, 32'h33, 32'h10, 1'b1, 3'b000, 5'd13, 1'b1, 1'b0);
        push_exp(32'h20, 32'h10, 32'h33, 3'b000, 5'd13, 1'b1, 1'b0);
        @(negedge clk);
        check("lu_stall", 32'(bus.id_ready), 32'd0);
        @(negedge clk);
        check("lu_bubble",  32'(bus.ex_valid),    32'd0);
        check("lu_gate_rw", 32'(bus.ex_regwrite), 32'd0);
        check("lu_gate_mr", 32'(bus.ex_memread),  32'd0);
        check("lu_rdy",     32'(bus.id_ready),    32'd1);
        tick();
        bus.id_valid = 1'b0;
        tick();

        // Flush kills both the held and the incoming instruction.
        bus.ex_ready = 1'b0;
        drive_id(5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 1'b0, 3'b000, 5'd14, 1'b1, 1'b0);
        tick();
        drive_id(5'd3, 5'd4, 32'h3, 32'h4, 32'h0, 1'b0, 3'b010, 5'd20, 1'b1, 1'b0);
        bus.flush = 1'b1;
        @(negedge clk);
        check("fl_rdy", 32'(bus.id_ready), 32'd0);
        tick();
        bus.flush = 1'b0;
        bus.id_valid = 1'b0;
        @(negedge clk);
        check("fl_vld",   32'(bus.ex_valid),    32'd0);
        check("fl_regwr", 32'(bus.ex_regwrite), 32'd0);
        check("fl_rd",    32'(bus.ex_rd_addr),  32'd14);
        tick();
        bus.ex_ready = 1'b1;
        tick();

        check("sb_drain", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
